pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Hazard and stall sequencer for the 3-stage IF/EXE/WB RISC-V pipeline. It drives the hold and bubble controls of the PC, the IF->EXE register and the EXE->WB register. It resolves three conditions:
- variable-latency DMEM wait (req/ack handshake),
- taken-branch/jump redirect flush,
- one-bubble load-use interlock.

It also keeps a sticky DMEM timeout flag and a saturating stall counter.

Parameters:
FLUSH_CYCLES, 1, IF->EXE bubbles inserted per taken redirect (1..3).
TIMEOUT, 64, max DMEM wait cycles before forced release; 0 disables the timeout.
CNT_W, 16, width of stall_count.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
exe_branch_taken  in  1  branch/jump in EXE resolved taken this cycle
exe_is_load  in  1  instruction in EXE is a load
exe_reg_we  in  1  instruction in EXE writes rd
exe_rd  in  5  destination register of EXE instruction
if_rs1  in  5  rs1 of instruction in IF
if_rs2  in  5  rs2 of instruction in IF
if_uses_rs1  in  1  IF instruction reads rs1
if_uses_rs2  in  1  IF instruction reads rs2
dmem_req  in  1  EXE instruction issues a DMEM access this cycle
dmem_ack  in  1  DMEM access complete
pc_stall  out  1  PC holds its value
if2exe_hold  out  1  IF->EXE register keeps its contents
if2exe_bubble  out  1  IF->EXE register loads NOP/zero controls
exe2wb_hold  out  1  EXE->WB register keeps its contents
exe2wb_bubble  out  1  EXE->WB register loads NOP/zero controls
kill_fetch  out  1  discard the IMEM word currently returning
mem_timeout  out  1  sticky: a DMEM wait hit TIMEOUT
ctrl_state  out  2  current FSM state (debug)
stall_count  out  CNT_W  saturating count of pc_stall cycles

Behaviour:
- Clocking and reset:
  - Clock is clk. Reset is rst, synchronous, active-high.
  - The FSM state, the counters and mem_timeout are registered.
  - The stall/bubble outputs are combinational from the state and the current inputs, so they act in the same cycle.
- Output values while rst is high:
  - if2exe_bubble=1 and exe2wb_bubble=1.
  - All other 1-bit outputs are 0.
- Register state on reset:
  - state=RUN, ctrl_state=0.
  - stall_count=0, mem_timeout=0, flush counter=0, wait counter=0.
- States: RUN=0, MEM_WAIT=1, REDIRECT=2. Encoding 3 is illegal and recovers to RUN with all outputs inactive.
- load_use = exe_is_load & exe_reg_we & (exe_rd!=0) & ((if_uses_rs1 & if_rs1==exe_rd) | (if_uses_rs2 & if_rs2==exe_rd)).
- RUN, evaluated in priority order:
  1. dmem_req & !dmem_ack:
     - assert pc_stall, if2exe_hold, exe2wb_bubble.
     - wait counter <= 1; go to MEM_WAIT.
     - Any branch or load_use in the same cycle is deferred until release.
  2. exe_branch_taken (including dmem_req & dmem_ack in the same cycle):
     - assert if2exe_bubble and kill_fetch.
     - If FLUSH_CYCLES>1: flush counter <= FLUSH_CYCLES-1; go to REDIRECT.
  3. load_use:
     - assert pc_stall and if2exe_bubble for exactly one cycle; stay in RUN.
     - The next cycle has a NOP in EXE, so no repeated stall occurs.
  4. Otherwise: all controls are 0.
- A zero-wait access (dmem_req & dmem_ack in the same cycle) causes no stall.
- MEM_WAIT:
  - While dmem_ack=0: hold the same controls as RUN case 1 and increment the wait counter.
  - On dmem_ack=1:
    - deassert all holds in that cycle; the EXE instruction advances to WB.
    - Then evaluate exe_branch_taken and load_use exactly as in RUN cases 2-4 and go to their next state.
  - If TIMEOUT!=0 and the wait counter == TIMEOUT:
    - set mem_timeout (sticky until rst);
    - release as if acked.
- REDIRECT:
  - Assert if2exe_bubble and kill_fetch; decrement the flush counter.
  - Go to RUN when the counter reaches 0.
  - dmem_req, exe_branch_taken and load_use are ignored, because EXE holds a bubble.
- Consistency rules:
  - Hold and bubble are never asserted on the same register in the same cycle.
  - exe2wb_hold is reserved: it stays 0 in all states.
- stall_count increments on every cycle with pc_stall=1 and rst=0, saturating at all-ones.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state typedef/localparams RUN/MEM_WAIT/REDIRECT;
  - the NOP instruction constant 32'h00000013, used by the pipeline registers on bubble.
- One natural sub-module: hazard_detect, the combinational load_use comparator. The FSM and counters stay in the top module.

Test Plan:
1. Reset: hold rst 3 cycles with random inputs -> both bubbles=1, other outputs 0; after release: ctrl_state=0, stall_count=0, mem_timeout=0.
2. Load-use: exe_is_load=1, exe_reg_we=1, exe_rd=5, if_rs2=5, if_uses_rs2=1 -> exactly 1 cycle of pc_stall=1 and if2exe_bubble=1; with exe_rd=0 -> no stall.
3. DMEM wait: dmem_req=1 with ack arriving 4 cycles later -> pc_stall, if2exe_hold, exe2wb_bubble high for 4 cycles, low in the ack cycle; stall_count=4.
4. Redirect: FLUSH_CYCLES=2, exe_branch_taken pulse -> if2exe_bubble and kill_fetch high for 2 consecutive cycles, ctrl_state 0->2->0.
5. Timeout: TIMEOUT=8, dmem_req held with no ack -> forced release after the 8th wait cycle, mem_timeout=1 and it stays 1 until rst.
6. Simultaneous events: dmem_req & !ack together with branch_taken -> stall first; at ack, redirect is applied in the same cycle. dmem_req & ack together with load_use -> a single load-use bubble, no memory stall.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: hazard FSM states and the NOP used for bubbles.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2,
    ILLEGAL  = 2'd3
  } ctrl_state_e;

  // addi x0, x0, 0 -- loaded by the pipeline registers on bubble
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EXE whose rd feeds a source of the IF instruction.
module hazard_detect (
  input  logic       exe_is_load,
  input  logic       exe_reg_we,
  input  logic [4:0] exe_rd,
  input  logic [4:0] if_rs1,
  input  logic [4:0] if_rs2,
  input  logic       if_uses_rs1,
  input  logic       if_uses_rs2,
  output logic       load_use
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit  = if_uses_rs1 && (if_rs1 == exe_rd);
  assign rs2_hit  = if_uses_rs2 && (if_rs2 == exe_rd);
  // x0 is never a real dependency
  assign load_use = exe_is_load && exe_reg_we && (exe_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the IF/EXE/WB pipeline: DMEM wait, redirect flush,
// load-use interlock, plus a sticky DMEM timeout flag and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT      = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exe_branch_taken,
  input  logic             exe_is_load,
  input  logic             exe_reg_we,
  input  logic [4:0]       exe_rd,
  input  logic [4:0]       if_rs1,
  input  logic [4:0]       if_rs2,
  input  logic             if_uses_rs1,
  input  logic             if_uses_rs2,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_stall,
  output logic             if2exe_hold,
  output logic             if2exe_bubble,
  output logic             exe2wb_hold,
  output logic             exe2wb_bubble,
  output logic             kill_fetch,
  output logic             mem_timeout,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  ctrl_state_e       state, state_n;
  logic [1:0]        flush_cnt, flush_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  logic              load_use, tmo, timeout_hit, release_eval;
  logic              stall_c, hold_c, bub_c, exb_c, kill_c;

  hazard_detect u_detect (
    .exe_is_load (exe_is_load),
    .exe_reg_we  (exe_reg_we),
    .exe_rd      (exe_rd),
    .if_rs1      (if_rs1),
    .if_rs2      (if_rs2),
    .if_uses_rs1 (if_uses_rs1),
    .if_uses_rs2 (if_uses_rs2),
    .load_use    (load_use)
  );

  assign tmo = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT));

  always_comb begin
    state_n      = state;
    flush_n      = flush_cnt;
    wait_n       = wait_cnt;
    timeout_hit  = 1'b0;
    release_eval = 1'b0;
    stall_c      = 1'b0;
    hold_c       = 1'b0;
    bub_c        = 1'b0;
    exb_c        = 1'b0;
    kill_c       = 1'b0;
    case (state)
      RUN: begin
        if (dmem_req && !dmem_ack) begin
          stall_c = 1'b1;
          hold_c  = 1'b1;
          exb_c   = 1'b1;
          wait_n  = WAIT_W'(1);
          state_n = MEM_WAIT;
        end else begin
          release_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack || tmo) begin
          timeout_hit  = tmo;
          release_eval = 1'b1;
        end else begin
          stall_c = 1'b1;
          hold_c  = 1'b1;
          exb_c   = 1'b1;
          if (wait_cnt != '1) wait_n = wait_cnt + WAIT_W'(1);
        end
      end
      REDIRECT: begin
        // EXE holds a bubble here, so no request, branch or load-use can be live
        bub_c  = 1'b1;
        kill_c = 1'b1;
        if (flush_cnt != 2'd0) flush_n = flush_cnt - 2'd1;
        if (flush_cnt <= 2'd1) state_n = RUN;
      end
      default: state_n = RUN;
    endcase

    // Shared tail of RUN and of a MEM_WAIT release: redirect beats load-use
    if (release_eval) begin
      state_n = RUN;
      if (exe_branch_taken) begin
        bub_c  = 1'b1;
        kill_c = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          flush_n = 2'(FLUSH_CYCLES - 1);
          state_n = REDIRECT;
        end
      end else if (load_use) begin
        stall_c = 1'b1;
        bub_c   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      flush_cnt   <= 2'd0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      state       <= state_n;
      flush_cnt   <= flush_n;
      wait_cnt    <= wait_n;
      mem_timeout <= mem_timeout | timeout_hit;
      if (stall_c && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign pc_stall      = !rst && stall_c;
  assign if2exe_hold   = !rst && hold_c;
  assign if2exe_bubble = rst || bub_c;
  assign exe2wb_hold   = 1'b0;
  assign exe2wb_bubble = rst || exb_c;
  assign kill_fetch    = !rst && kill_c;
  assign ctrl_state    = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with FLUSH_CYCLES=2, TIMEOUT=8.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_branch_taken, exe_is_load, exe_reg_we;
  logic [4:0]  exe_rd, if_rs1, if_rs2;
  logic        if_uses_rs1, if_uses_rs2, dmem_req, dmem_ack;
  logic        pc_stall, if2exe_hold, if2exe_bubble, exe2wb_hold, exe2wb_bubble;
  logic        kill_fetch, mem_timeout;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_count;

  int n_chk  = 0;
  int n_pass = 0;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .TIMEOUT(8), .CNT_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .exe_branch_taken (exe_branch_taken),
    .exe_is_load      (exe_is_load),
    .exe_reg_we       (exe_reg_we),
    .exe_rd           (exe_rd),
    .if_rs1           (if_rs1),
    .if_rs2           (if_rs2),
    .if_uses_rs1      (if_uses_rs1),
    .if_uses_rs2      (if_uses_rs2),
    .dmem_req         (dmem_req),
    .dmem_ack         (dmem_ack),
    .pc_stall         (pc_stall),
    .if2exe_hold      (if2exe_hold),
    .if2exe_bubble    (if2exe_bubble),
    .exe2wb_hold      (exe2wb_hold),
    .exe2wb_bubble    (exe2wb_bubble),
    .kill_fetch       (kill_fetch),
    .mem_timeout      (mem_timeout),
    .ctrl_state       (ctrl_state),
    .stall_count      (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // pack the six 1-bit controls: {pc_stall, hold, bubble, exe2wb_hold, exe2wb_bubble, kill}
  function automatic logic [5:0] ctl();
    return {pc_stall, if2exe_hold, if2exe_bubble, exe2wb_hold, exe2wb_bubble, kill_fetch};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    exe_branch_taken = 0; exe_is_load = 0; exe_reg_we = 0; exe_rd = 0;
    if_rs1 = 0; if_rs2 = 0; if_uses_rs1 = 0; if_uses_rs2 = 0;
    dmem_req = 0; dmem_ack = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc();
    rst = 0;
    #2;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
    exe_is_load = 1; exe_reg_we = 1; exe_rd = rd;
    if_rs1 = rs1; if_uses_rs1 = u1; if_rs2 = rs2; if_uses_rs2 = u2;
  endtask

  initial begin
    idle();
    rst = 1;
    #1;
    // 1. reset with random inputs
    for (int i = 0; i < 3; i++) begin
      {exe_branch_taken, exe_is_load, exe_reg_we, if_uses_rs1, if_uses_rs2, dmem_req, dmem_ack} = 7'($urandom);
      exe_rd = 5'($urandom); if_rs1 = 5'($urandom); if_rs2 = 5'($urandom);
      #2;
      chk("rst_ctl", 32'(ctl()), 32'b001010);
      chk("rst_tmo", 32'(mem_timeout), 0);
      cyc();
    end
    idle();
    rst = 0;
    #2;
    chk("post_rst_state", 32'(ctrl_state), 0);
    chk("post_rst_cnt", 32'(stall_count), 0);
    chk("post_rst_tmo", 32'(mem_timeout), 0);
    chk("idle_ctl", 32'(ctl()), 0);

    // 2. load-use on rs2, then NOP in EXE, then x0 and unused-source cases
    set_load(5'd5, 5'd1, 1'b1, 5'd5, 1'b1);
    #1;
    chk("lu_rs2_ctl", 32'(ctl()), 32'b101000);
    cyc();
    idle();
    #1;
    chk("lu_after_ctl", 32'(ctl()), 0);
    chk("lu_after_state", 32'(ctrl_state), 0);
    chk("lu_cnt", 32'(stall_count), 1);
    set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    chk("lu_x0_ctl", 32'(ctl()), 0);
    set_load(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
    #1;
    chk("lu_unused_ctl", 32'(ctl()), 0);
    set_load(5'd7, 5'd7, 1'b1, 5'd3, 1'b0);
    #1;
    chk("lu_rs1_ctl", 32'(ctl()), 32'b101000);
    cyc();
    idle();

    // 3. DMEM wait, ack four cycles after the request
    do_reset();
    dmem_req = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("dw_stall_ctl", 32'(ctl()), 32'b110010);
      chk("dw_state", 32'(ctrl_state), (i == 0) ? 0 : 1);
      cyc();
    end
    dmem_ack = 1;
    #1;
    chk("dw_ack_ctl", 32'(ctl()), 0);
    cyc();
    idle();
    #1;
    chk("dw_done_state", 32'(ctrl_state), 0);
    chk("dw_cnt", 32'(stall_count), 4);

    // 4. redirect, two flush cycles; load-use ignored during REDIRECT
    do_reset();
    exe_branch_taken = 1;
    #1;
    chk("br_ctl0", 32'(ctl()), 32'b001001);
    chk("br_state0", 32'(ctrl_state), 0);
    cyc();
    idle();
    set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    dmem_req = 1;
    #1;
    chk("br_ctl1", 32'(ctl()), 32'b001001);
    chk("br_state1", 32'(ctrl_state), 2);
    cyc();
    idle();
    #1;
    chk("br_ctl2", 32'(ctl()), 0);
    chk("br_state2", 32'(ctrl_state), 0);

    // 5. timeout: 8 stall cycles, release on the 9th, sticky flag
    do_reset();
    dmem_req = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_stall", 32'(pc_stall), 1);
      cyc();
    end
    #1;
    chk("to_rel_ctl", 32'(ctl()), 0);
    chk("to_rel_state", 32'(ctrl_state), 1);
    chk("to_rel_flag", 32'(mem_timeout), 0);
    cyc();
    dmem_req = 0;
    #1;
    chk("to_flag", 32'(mem_timeout), 1);
    chk("to_state", 32'(ctrl_state), 0);
    chk("to_cnt", 32'(stall_count), 8);
    cyc();
    cyc();
    chk("to_sticky", 32'(mem_timeout), 1);
    do_reset();
    chk("to_cleared", 32'(mem_timeout), 0);

    // 6a. stall with pending branch; redirect applied in the ack cycle
    dmem_req = 1;
    exe_branch_taken = 1;
    #1;
    chk("sim_stall0", 32'(ctl()), 32'b110010);
    cyc();
    #1;
    chk("sim_stall1", 32'(ctl()), 32'b110010);
    cyc();
    dmem_ack = 1;
    #1;
    chk("sim_ack_ctl", 32'(ctl()), 32'b001001);
    cyc();
    idle();
    #1;
    chk("sim_redir_state", 32'(ctrl_state), 2);
    chk("sim_redir_ctl", 32'(ctl()), 32'b001001);
    cyc();
    #1;
    chk("sim_back_state", 32'(ctrl_state), 0);

    // 6b. zero-wait access with load-use: only the load-use bubble
    dmem_req = 1;
    dmem_ack = 1;
    set_load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    #1;
    chk("zw_lu_ctl", 32'(ctl()), 32'b101000);
    cyc();
    idle();
    #1;
    chk("zw_lu_state", 32'(ctrl_state), 0);
    chk("zw_lu_after", 32'(ctl()), 0);
    chk("zw_cnt", 32'(stall_count), 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
